// File: rtl/ptp_extts.sv
// External event timestamper: synchronises event_in, filters edges by minimum width,
// compensates latency and queues stamps on an AXI stream. Option macro: PTP_EXTTS_STEP_DROP_EN.
module ptp_extts #(
   parameter int TS_WIDTH    = 96,
   parameter int SYNC_STAGES = 2,
   parameter int MIN_WIDTH   = 4,
   parameter int EDGE_SEL    = 0,
   parameter int COMP_NS     = 0,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [TS_WIDTH-1:0] input_ts_96,
   input  logic                input_ts_step,
   input  logic                enable,
   input  logic                event_in,
   output logic [TS_WIDTH-1:0] m_axis_ts_96,
   output logic                m_axis_ts_edge,
   output logic                m_axis_ts_valid,
   input  logic                m_axis_ts_ready,
   output logic                overflow,
   output logic [15:0]         event_count,
   output logic                step_drop
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int HW = $clog2(SYNC_STAGES + 2);
   localparam logic [HW-1:0] HOLD_INIT = HW'(SYNC_STAGES + 1);
   localparam logic [31:0]   COMP      = 32'(COMP_NS);
   localparam logic [31:0]   NS_PER_S  = 32'd1000000000;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s_lvl;
   logic [HW-1:0]          hold_q;
   logic                   step_in;

   logic                   level_q, level_d;
   logic                   cand_q, cand_d;
   logic [7:0]             cnt_q, cnt_d, run_len;
   logic [TS_WIDTH-1:0]    cand_ts_q, cand_ts_d;
   logic                   cand_edge_q, cand_edge_d;
   logic                   step_seen_q, step_seen_d;

   logic                   accept, edge_match, push_d;
   logic [TS_WIDTH-1:0]    acc_ts, comp_ts;
   logic                   acc_edge, acc_step;
   logic [32:0]            ns_diff;

   logic                   push_q;
   logic [TS_WIDTH-1:0]    push_ts_q;
   logic                   push_edge_q;
   logic [15:0]            count_q;

   logic [TS_WIDTH:0]      mem [FIFO_DEPTH];
   logic [AW:0]            wr_q, rd_q;
   logic                   empty, full, pop, wr_en;
   logic [TS_WIDTH:0]      head;

`ifdef PTP_EXTTS_STEP_DROP_EN
   logic                   sdrop_q;
   assign step_in   = input_ts_step;
   assign step_drop = sdrop_q;
`else
   logic                   unused_step;
   assign unused_step = input_ts_step;
   assign step_in     = 1'b0;
   assign step_drop   = 1'b0;
`endif

   assign s_lvl = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         hold_q <= HOLD_INIT;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], event_in};
         if (hold_q != '0) hold_q <= hold_q - 1'b1;
      end
   end

   // Edge filter: the candidate is seeded on the first cycle S differs from L
   // and accepted once the new level has been seen for MIN_WIDTH cycles.
   always_comb begin
      level_d     = level_q;
      cand_d      = cand_q;
      cnt_d       = cnt_q;
      cand_ts_d   = cand_ts_q;
      cand_edge_d = cand_edge_q;
      step_seen_d = step_seen_q;
      accept      = 1'b0;
      run_len     = cand_q ? cnt_q + 8'd1 : 8'd1;
      acc_ts      = cand_q ? cand_ts_q : input_ts_96;
      acc_edge    = cand_q ? cand_edge_q : s_lvl;
      acc_step    = (cand_q & step_seen_q) | step_in;
      if (hold_q != '0 || !enable) begin
         level_d     = s_lvl;
         cand_d      = 1'b0;
         cnt_d       = 8'd0;
         step_seen_d = 1'b0;
      end else if (s_lvl != level_q) begin
         cand_ts_d   = acc_ts;
         cand_edge_d = acc_edge;
         step_seen_d = acc_step;
         if (run_len == 8'(MIN_WIDTH)) begin
            accept  = 1'b1;
            level_d = s_lvl;
            cand_d  = 1'b0;
            cnt_d   = 8'd0;
         end else begin
            cand_d = 1'b1;
            cnt_d  = run_len;
         end
      end else begin
         cand_d = 1'b0;
         cnt_d  = 8'd0;
      end
   end

   always_comb begin
      case (EDGE_SEL)
         0:       edge_match = acc_edge;
         1:       edge_match = ~acc_edge;
         default: edge_match = 1'b1;
      endcase
   end

   // Borrow from seconds when the latency correction underflows nanoseconds.
   assign ns_diff = {1'b0, acc_ts[47:16]} - {1'b0, COMP};
   always_comb begin
      comp_ts = acc_ts;
      if (ns_diff[32]) begin
         comp_ts[95:48] = acc_ts[95:48] - 48'd1;
         comp_ts[47:16] = acc_ts[47:16] + NS_PER_S - COMP;
      end else begin
         comp_ts[47:16] = ns_diff[31:0];
      end
   end

   assign push_d = accept & edge_match & ~acc_step;

   always_ff @(posedge clk) begin
      if (rst) begin
         level_q     <= 1'b0;
         cand_q      <= 1'b0;
         cnt_q       <= 8'd0;
         cand_ts_q   <= '0;
         cand_edge_q <= 1'b0;
         step_seen_q <= 1'b0;
         push_q      <= 1'b0;
         push_ts_q   <= '0;
         push_edge_q <= 1'b0;
         count_q     <= 16'd0;
      end else begin
         level_q     <= level_d;
         cand_q      <= cand_d;
         cnt_q       <= cnt_d;
         cand_ts_q   <= cand_ts_d;
         cand_edge_q <= cand_edge_d;
         step_seen_q <= step_seen_d;
         push_q      <= push_d;
         push_ts_q   <= comp_ts;
         push_edge_q <= acc_edge;
         if (push_d) count_q <= count_q + 16'd1;
      end
   end

`ifdef PTP_EXTTS_STEP_DROP_EN
   always_ff @(posedge clk) begin
      if (rst) sdrop_q <= 1'b0;
      else     sdrop_q <= accept & edge_match & acc_step;
   end
`endif

   // First-word-fall-through queue of {edge, timestamp}.
   assign empty = (wr_q == rd_q);
   assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign pop   = !empty && m_axis_ts_ready;
   assign wr_en = push_q && (!full || pop);

   always_ff @(posedge clk) begin
      if (!rst && wr_en) mem[wr_q[AW-1:0]] <= {push_edge_q, push_ts_q};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (wr_en) wr_q <= wr_q + 1'b1;
         if (pop)   rd_q <= rd_q + 1'b1;
      end
   end

   assign head            = mem[rd_q[AW-1:0]];
   assign m_axis_ts_valid = !empty;
   assign m_axis_ts_96    = empty ? '0 : head[TS_WIDTH-1:0];
   assign m_axis_ts_edge  = !empty && head[TS_WIDTH];
   assign overflow        = push_q && full && !pop;
   assign event_count     = count_q;
endmodule

// File: tb/tb_ptp_extts.sv
// Randomised bench for ptp_extts with a window-based reference model and scoreboard.
`timescale 1ns/1ps
module tb_ptp_extts;
   localparam int SYNC  = 2;
   localparam int MW    = 4;
   localparam int DEPTH = 4;
   localparam int COMP  = 200;
   localparam int ESEL  = 2;
   localparam int HMAX  = 8192;
`ifdef PTP_EXTTS_STEP_DROP_EN
   localparam bit STEP_EN = 1'b1;
`else
   localparam bit STEP_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, ts_step, enable, event_in, ready;
   logic [95:0] ts_in;
   logic [95:0] ts_out;
   logic        edge_out, valid, overflow, step_drop;
   logic [15:0] event_count;

   always #5 clk = ~clk;

   ptp_extts #(
      .TS_WIDTH(96), .SYNC_STAGES(SYNC), .MIN_WIDTH(MW), .EDGE_SEL(ESEL),
      .COMP_NS(COMP), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst(rst), .input_ts_96(ts_in), .input_ts_step(ts_step),
      .enable(enable), .event_in(event_in), .m_axis_ts_96(ts_out),
      .m_axis_ts_edge(edge_out), .m_axis_ts_valid(valid), .m_axis_ts_ready(ready),
      .overflow(overflow), .event_count(event_count), .step_drop(step_drop)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check_val(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Stimulus knobs
   bit          ts_hold = 1'b0;
   logic [95:0] ts_val  = '0;
   int          ready_mode = 1;
   int          ready_pct  = 50;
   bit          step_rand  = 1'b0;

   function automatic logic [95:0] rand_ts();
      logic [63:0] r;
      logic [47:0] s;
      logic [31:0] ns;
      logic [15:0] f;
      r  = {$urandom, $urandom};
      s  = r[47:0];
      if ($urandom_range(0, 7) == 0) s = '0;
      ns = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 399))
                                       : 32'($urandom_range(0, 999999999));
      f  = 16'($urandom);
      return {s, ns, f};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      ts_in = ts_hold ? ts_val : rand_ts();
      case (ready_mode)
         0:       ready = 1'b0;
         1:       ready = 1'b1;
         default: ready = ($urandom_range(0, 99) < ready_pct);
      endcase
      ts_step = step_rand && ($urandom_range(0, 29) == 0);
      #1;
   endtask

   // Reference model
   typedef struct {
      logic [95:0] ts;
      logic        edg;
   } entry_t;

   entry_t      mq[$];
   entry_t      pend_e;
   bit          in_h [HMAX];
   bit          en_h [HMAX];
   bit          st_h [HMAX];
   logic [95:0] ts_h [HMAX];
   int          t = 0;
   int          rel = 0;
   int          cnt_m = 0;
   bit          lvl_m = 1'b0;
   bit          pend_push = 1'b0;
   bit          pend_sdrop = 1'b0;
   bit          in_rst_state = 1'b1;

   function automatic logic [95:0] comp_model(input logic [95:0] ts);
      longint      ns;
      logic [47:0] s;
      ns = longint'(ts[47:16]);
      s  = ts[95:48];
      if (ns >= COMP) ns = ns - COMP;
      else begin
         ns = ns + 1000000000 - COMP;
         s  = s - 48'd1;
      end
      return {s, 32'(ns), ts[15:0]};
   endfunction

   // Synchroniser output as seen by the filter: input delayed SYNC cycles, zero until refilled after reset.
   function automatic bit s_at(input int u);
      return (u - SYNC >= rel) ? in_h[u - SYNC] : 1'b0;
   endfunction

   always @(negedge clk) begin
      bit exp_v, pop, s_now, acc, stp, match;
      if (t < HMAX) begin
         in_h[t] = event_in;
         en_h[t] = enable;
         st_h[t] = ts_step;
         ts_h[t] = ts_in;

         exp_v = (mq.size() != 0);
         check_val("valid", valid, exp_v);
         if (exp_v) begin
            check_val("ts", ts_out, mq[0].ts);
            check_val("edge", edge_out, mq[0].edg);
         end else if (in_rst_state) begin
            check_val("rst_ts", ts_out, 96'd0);
            check_val("rst_edge", edge_out, 1'b0);
         end
         pop = exp_v && ready;
         check_val("overflow", overflow, pend_push && (mq.size() == DEPTH) && !pop);
         check_val("count", event_count, 16'(cnt_m));
         check_val("step_drop", step_drop, pend_sdrop);
         if (pop) $display("pop t=%0d edge=%0d ts=%h", t, mq[0].edg, mq[0].ts);

         if (rst) begin
            mq.delete();
            cnt_m        = 0;
            pend_push    = 1'b0;
            pend_sdrop   = 1'b0;
            lvl_m        = 1'b0;
            rel          = t + 1;
            in_rst_state = 1'b1;
         end else begin
            in_rst_state = 1'b0;
            if (pop) void'(mq.pop_front());
            if (pend_push && mq.size() < DEPTH) mq.push_back(pend_e);
            pend_push  = 1'b0;
            pend_sdrop = 1'b0;
            s_now = s_at(t);
            if (t - rel <= SYNC || !enable) begin
               lvl_m = s_now;
            end else if (t - rel >= SYNC + MW) begin
               acc = 1'b1;
               stp = 1'b0;
               for (int k = 0; k < MW; k++) begin
                  if (!en_h[t-k] || s_at(t-k) == lvl_m) acc = 1'b0;
                  stp = stp | st_h[t-k];
               end
               if (acc) begin
                  lvl_m = s_now;
                  match = (ESEL == 2) || (ESEL == 0 && s_now) || (ESEL == 1 && !s_now);
                  if (match) begin
                     if (stp && STEP_EN) pend_sdrop = 1'b1;
                     else begin
                        pend_push  = 1'b1;
                        pend_e.ts  = comp_model(ts_h[t-MW+1]);
                        pend_e.edg = s_now;
                        cnt_m      = (cnt_m + 1) & 16'hffff;
                     end
                  end
               end
            end
         end
         t++;
      end
   end

   initial begin
      int len;
      int ovf_seen;
      rst = 1'b1; event_in = 1'b0; enable = 1'b1; ts_step = 1'b0; ts_in = '0; ready = 1'b1;
      repeat (5) tick();
      rst = 1'b0;
      repeat (12) tick();
      check_val("rst_cnt", event_count, 16'd0);
      check_val("rst_valid", valid, 1'b0);

      // Latency and nanosecond borrow: s=7 ns=50 with 200 ns compensation.
      ready_mode = 0;
      ts_hold    = 1'b1;
      ts_val     = {48'd7, 32'd50, 16'h1234};
      tick();
      event_in = 1'b1;
      repeat (5) tick();
      check_val("cnt_at_A", event_count, 16'd0);
      tick();
      check_val("cnt_at_A1", event_count, 16'd1);
      check_val("valid_at_A1", valid, 1'b0);
      tick();
      check_val("valid_at_A2", valid, 1'b1);
      check_val("comp_ts", ts_out, {48'd6, 32'd999999850, 16'h1234});
      check_val("comp_edge", edge_out, 1'b1);
      ts_hold = 1'b0;

      // Glitch shorter than the minimum width.
      event_in = 1'b0;
      repeat (3) tick();
      event_in = 1'b1;
      repeat (10) tick();
      check_val("glitch_cnt", event_count, 16'd1);
      check_val("glitch_valid", valid, 1'b1);
      ready_mode = 1;
      repeat (3) tick();
      check_val("drained", valid, 1'b0);

      // Five events into a four-deep queue with the sink stalled.
      ready_mode = 0;
      ovf_seen   = 0;
      for (int i = 0; i < 5; i++) begin
         event_in = ~event_in;
         repeat (6) begin
            tick();
            ovf_seen += int'(overflow);
         end
      end
      repeat (4) begin
         tick();
         ovf_seen += int'(overflow);
      end
      check_val("ovf_pulses", ovf_seen, 1);
      check_val("ovf_cnt", event_count, 16'd6);
      check_val("ovf_valid", valid, 1'b1);
      ready_mode = 1;
      repeat (8) tick();
      check_val("ovf_drained", valid, 1'b0);

      // Input held high through reset, then a falling edge.
      ready_mode = 0;
      event_in   = 1'b1;
      rst        = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      repeat (12) tick();
      check_val("hold_cnt", event_count, 16'd0);
      check_val("hold_valid", valid, 1'b0);
      event_in = 1'b0;
      repeat (8) tick();
      check_val("fall_cnt", event_count, 16'd1);
      check_val("fall_valid", valid, 1'b1);
      check_val("fall_edge", edge_out, 1'b0);
      ready_mode = 1;
      repeat (5) tick();

      // Randomised traffic: bursty ready, enable drops, steps and occasional resets.
      ready_mode = 2;
      step_rand  = 1'b1;
      for (int seg = 0; seg < 400; seg++) begin
         if (seg % 40 == 0) ready_pct = (seg % 120 == 0) ? 10 : ((seg % 80 == 0) ? 90 : 50);
         len    = $urandom_range(1, 10);
         enable = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 99) == 0) begin
            rst = 1'b1;
            tick();
            tick();
            rst = 1'b0;
         end
         event_in = ~event_in;
         repeat (len) tick();
      end

      ready_mode = 1;
      step_rand  = 1'b0;
      enable     = 1'b1;
      repeat (30) tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
